// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-side hazard unit for the 16-bit five-stage core.
// Tracks the destination registers in flight in EX/MEM/WB and derives
// EX operand forwarding, the WB-to-ID bypass, the load-use stall and the
// taken-branch flush, plus saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_rs1,
  input  logic [3:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [3:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             branch_taken,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             id_bypass_a,
  output logic             id_bypass_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Slot control bits (reset) and slot payload (no reset needed: qualified by valid)
  logic             ex_valid_q, ex_valid_d;
  logic             mem_valid_q, mem_valid_d;
  logic             wb_valid_q, wb_valid_d;
  logic [3:0]       ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic             ex_rw_q, ex_rw_d, mem_rw_q, mem_rw_d, wb_rw_q, wb_rw_d;
  logic             ex_ld_q, ex_ld_d, mem_ld_q, mem_ld_d, wb_ld_q, wb_ld_d;
  logic [3:0]       ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic             ex_u1_q, ex_u1_d, ex_u2_q, ex_u2_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // A slot produces rN when it is live, writes the regfile and targets rN.
  function automatic logic is_prod(input logic v, input logic rw,
                                   input logic [3:0] rd, input logic [3:0] n);
    return v & rw & (rd == n);
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Operand select for one EX source; a MEM-slot load falls through to WB/regfile.
  function automatic logic [1:0] fwd_sel(input logic v, input logic uses,
                                         input logic [3:0] rs,
                                         input logic m_v, input logic m_rw,
                                         input logic [3:0] m_rd, input logic m_ld,
                                         input logic w_v, input logic w_rw,
                                         input logic [3:0] w_rd);
    if (!uses || !v)                             return FWD_REG;
    else if (is_prod(m_v, m_rw, m_rd, rs) && !m_ld) return FWD_MEM;
    else if (is_prod(w_v, w_rw, w_rd, rs))       return FWD_WB;
    else                                         return FWD_REG;
  endfunction

  // Hazard decisions from ID fields and the registered slots.
  always_comb begin
    flush = branch_taken;
    stall = !branch_taken & id_valid & ex_ld_q &
            ((id_uses_rs1 & is_prod(ex_valid_q, ex_rw_q, ex_rd_q, id_rs1)) |
             (id_uses_rs2 & is_prod(ex_valid_q, ex_rw_q, ex_rd_q, id_rs2)));
    id_bypass_a = id_valid & id_uses_rs1 & is_prod(wb_valid_q, wb_rw_q, wb_rd_q, id_rs1);
    id_bypass_b = id_valid & id_uses_rs2 & is_prod(wb_valid_q, wb_rw_q, wb_rd_q, id_rs2);
    fwd_a = fwd_sel(ex_valid_q, ex_u1_q, ex_rs1_q, mem_valid_q, mem_rw_q, mem_rd_q,
                    mem_ld_q, wb_valid_q, wb_rw_q, wb_rd_q);
    fwd_b = fwd_sel(ex_valid_q, ex_u2_q, ex_rs2_q, mem_valid_q, mem_rw_q, mem_rd_q,
                    mem_ld_q, wb_valid_q, wb_rw_q, wb_rd_q);
  end

  // Next slot contents: the shadow pipeline shifts every cycle, EX takes ID or a bubble.
  always_comb begin
    ex_valid_d  = id_valid & !stall & !flush;
    ex_rd_d     = id_rd;
    ex_rw_d     = id_reg_write;
    ex_ld_d     = id_is_load;
    ex_rs1_d    = id_rs1;
    ex_rs2_d    = id_rs2;
    ex_u1_d     = id_uses_rs1;
    ex_u2_d     = id_uses_rs2;
    mem_valid_d = ex_valid_q;
    mem_rd_d    = ex_rd_q;
    mem_rw_d    = ex_rw_q;
    mem_ld_d    = ex_ld_q;
    wb_valid_d  = mem_valid_q;
    wb_rd_d     = mem_rd_q;
    wb_rw_d     = mem_rw_q;
    wb_ld_d     = mem_ld_q;
    stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  // Control state: slot valids and counters, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Slot payload registers; meaningless whenever the matching valid is low.
  always_ff @(posedge clk) begin
    ex_rd_q  <= ex_rd_d;
    ex_rw_q  <= ex_rw_d;
    ex_ld_q  <= ex_ld_d;
    ex_rs1_q <= ex_rs1_d;
    ex_rs2_q <= ex_rs2_d;
    ex_u1_q  <= ex_u1_d;
    ex_u2_q  <= ex_u2_d;
    mem_rd_q <= mem_rd_d;
    mem_rw_q <= mem_rw_d;
    mem_ld_q <= mem_ld_d;
    wb_rd_q  <= wb_rd_d;
    wb_rw_q  <= wb_rw_d;
    wb_ld_q  <= wb_ld_d;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 16-bit five-stage core (IF/ID/EX/MEM/WB). It keeps a shadow of the destination registers in flight in EX, MEM and WB. From that shadow it drives operand-forwarding selects into EX, a write-back-to-ID bypass, the load-use stall and the taken-branch flush. It sits beside the decode stage, takes the decoded register fields and control bits, and keeps saturating stall and flush event counters for performance debug.

## Interface
- CNT_W, 16, width of the stall and flush event counters
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  4 each  source register fields of the ID instruction
- id_uses_rs1, id_uses_rs2  in  1 each  source actually read (0 for unused or immediate operand)
- id_rd  in  4  destination field of the ID instruction
- id_reg_write  in  1  ID instruction writes the register file
- id_is_load  in  1  ID instruction is a load (data ready at end of MEM)
- branch_taken  in  1  branch or jump resolved taken in EX this cycle
- stall  out  1  hold PC and the IF/ID register; bubble into EX
- flush  out  1  invalidate IF/ID; the ID instruction does not enter EX
- fwd_a, fwd_b  out  2 each  EX operand select: 00 ID-read data, 01 EX/MEM ALU result, 10 MEM/WB write-back data
- id_bypass_a, id_bypass_b  out  1 each  ID must take the WB write data instead of the regfile read
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- State: three slots (EX, MEM, WB). Each slot holds valid, rd, reg_write and is_load. The EX slot also holds rs1, rs2, uses_rs1 and uses_rs2.
- Advance every cycle. There is no downstream back-pressure.
  - WB slot loads the MEM slot; MEM slot loads the EX slot.
  - EX slot loads the ID fields when id_valid & !stall & !flush; otherwise it loads a bubble (valid=0).
- A slot is a "producer" of rN when valid & reg_write & rd==N. r0 is an ordinary register with no special-casing.
- Load-use stall (combinational): stall = !branch_taken & id_valid & the EX slot is a producer of id_rs1 (with id_uses_rs1) or of id_rs2 (with id_uses_rs2) & the EX slot is_load. There is exactly one stall cycle per load-use, because after it the load sits in WB-forwardable position.
- Flush: flush = branch_taken. branch_taken wins over stall, so stall=0 whenever flush=1.
- Forwarding for the EX slot, operand A, evaluated in priority order (operand B identical using rs2/uses_rs2):
  - uses_rs1=0 or EX slot invalid: 00
  - MEM slot is a producer of rs1 and not is_load: 01
  - WB slot is a producer of rs1: 10
  - otherwise: 00
- A MEM-slot load matching an EX source cannot occur because the stall prevents it. If it does occur, the select falls through to the WB/00 rules.
- ID bypass: id_bypass_a = id_valid & id_uses_rs1 & the WB slot is a producer of id_rs1. This covers the same-edge regfile write, whose combinational read returns the old value. id_bypass_b is the same using rs2.
- Counters:
  - stall_cnt increments on every cycle with stall=1.
  - flush_cnt increments on every cycle with flush=1.
  - Both saturate at all-ones.

## Timing
- Reset (asynchronous): all slots are invalid and both counters are 0. Consequently stall=0, flush=0, fwd_a=fwd_b=00 and id_bypass_a=id_bypass_b=0 while rst is high and after release until valid instructions arrive.
- stall, flush and id_bypass_* are combinational from the ID inputs, branch_taken and the registered slots, valid in the same cycle.
- fwd_a and fwd_b depend only on registered slots, so they are stable from the clock edge for the whole EX cycle.
- Producer-to-consumer distance:
  - distance 1 (ALU result): fwd=01, no stall
  - distance 2: fwd=10
  - distance 3: id_bypass=1 while the consumer is in ID
  - distance 4 and above: regfile read, no action
- Reset mid-stream discards all in-flight slot state immediately. Counters restart from 0.
- Counter increments take effect at the next rising edge.

## Test plan
- Assert and release reset mid-stream with a load in EX → all outputs 0 immediately, stall_cnt=0, and there is no stall on the following instruction.
- ADD r1,r2,r3 then ADD r5,r1,r1 back-to-back → in the second instruction's EX cycle, fwd_a=fwd_b=01 and stall is never asserted.
- Load r4, then ADD r6,r4,r7 (uses_rs2=1, rs2=r7) → stall=1 for exactly one cycle and EX gets a bubble. In the ADD's EX cycle, fwd_a=10 and fwd_b=00. stall_cnt=1.
- ADD r1; NOP; NOP; SUB r2,r1,r1 → id_bypass_a=id_bypass_b=1 for one cycle while SUB is in ID, and fwd stays 00 in its EX cycle.
- ADDI r3 with id_uses_rs2=0 and id_rs2 field equal to the rd of a load in EX → stall=0.
- branch_taken=1 in the same cycle as a load-use condition → flush=1, stall=0, EX slot invalid next cycle, flush_cnt +1, stall_cnt unchanged. Holding branch_taken for 2^CNT_W+5 cycles leaves flush_cnt saturated at all-ones.
